// File: rtl/name_entry.sv
// Team-name entry controller for the welcome menu: edits a fixed-length name one
// character at a time with the direction buttons and confirms it with chop.
//
// state   | meaning
// IDLE    | menu inactive, name and cursor retained
// ARM     | waiting for all buttons released before editing
// EDIT    | accepting one button press
// HOLD    | press in progress, up/down auto-repeat
// CONFIRM | chop pressed, waiting for its release
// DONE    | name confirmed, waiting for enable to drop
module name_entry #(
   parameter int          NUM_CHARS     = 3,
   parameter logic [7:0]  CHAR_LO       = 8'h41,
   parameter logic [7:0]  CHAR_HI       = 8'h5A,
   parameter int          REPEAT_DELAY  = 25_000_000,
   parameter int          REPEAT_PERIOD = 5_000_000,
   localparam int         CUR_W         = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      left,
   input  logic                      right,
   input  logic                      up,
   input  logic                      down,
   input  logic                      chop,
   output logic [NUM_CHARS-1:0][7:0] name,
   output logic [CUR_W-1:0]          cursor,
   output logic                      editing,
   output logic                      done
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CUR_W-1:0] LAST_POS  = CUR_W'(NUM_CHARS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      EDIT    = 3'd2,
      HOLD    = 3'd3,
      CONFIRM = 3'd4,
      DONE    = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      REP_NONE = 2'd0,
      REP_UP   = 2'd1,
      REP_DN   = 2'd2
   } rep_t;

   state_t           state;
   rep_t             hold_btn;
   logic             rep_late;
   logic [CNT_W-1:0] rep_cnt;

   logic             any;
   logic [CUR_W-1:0] sel_idx;
   logic [7:0]       sel_char;
   logic             rep_hi;
   logic [CNT_W-1:0] rep_tc;

   // Out-of-range codes snap to the end the player is moving toward.
   function automatic logic [7:0] char_dec(input logic [7:0] c);
      if (c <= CHAR_LO || c > CHAR_HI) return CHAR_HI;
      return c - 8'd1;
   endfunction

   function automatic logic [7:0] char_inc(input logic [7:0] c);
      if (c >= CHAR_HI || c < CHAR_LO) return CHAR_LO;
      return c + 8'd1;
   endfunction

   assign any      = left | right | up | down | chop;
   assign sel_idx  = LAST_POS - cursor;
   assign sel_char = name[sel_idx];
   assign rep_hi   = (hold_btn == REP_UP && up) || (hold_btn == REP_DN && down);
   assign rep_tc   = rep_late ? PERIOD_TC : DELAY_TC;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         name     <= {NUM_CHARS{CHAR_LO}};
         cursor   <= '0;
         editing  <= 1'b0;
         done     <= 1'b0;
         hold_btn <= REP_NONE;
         rep_late <= 1'b0;
         rep_cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && !enable) begin
            state    <= IDLE;
            editing  <= 1'b0;
            hold_btn <= REP_NONE;
         end else begin
            case (state)
               IDLE: begin
                  if (enable) begin
                     state  <= ARM;
                     cursor <= '0;
                  end
               end
               ARM: begin
                  if (!any) begin
                     state   <= EDIT;
                     editing <= 1'b1;
                  end
               end
               EDIT: begin
                  if (any) begin
                     rep_cnt  <= '0;
                     rep_late <= 1'b0;
                     hold_btn <= REP_NONE;
                     if (chop) begin
                        state   <= CONFIRM;
                        editing <= 1'b0;
                     end else begin
                        state <= HOLD;
                        if (up) begin
                           name[sel_idx] <= char_dec(sel_char);
                           hold_btn      <= REP_UP;
                        end else if (down) begin
                           name[sel_idx] <= char_inc(sel_char);
                           hold_btn      <= REP_DN;
                        end else if (right) begin
                           if (cursor != LAST_POS) cursor <= cursor + 1'b1;
                        end else if (cursor != '0) begin
                           cursor <= cursor - 1'b1;
                        end
                     end
                  end
               end
               HOLD: begin
                  if (!any) begin
                     state    <= EDIT;
                     hold_btn <= REP_NONE;
                  end else if (rep_hi) begin
                     if (rep_cnt == rep_tc) begin
                        name[sel_idx] <= (hold_btn == REP_UP) ? char_dec(sel_char)
                                                              : char_inc(sel_char);
                        rep_cnt  <= '0;
                        rep_late <= 1'b1;
                     end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                     end
                  end else begin
                     // Originating button let go while another is held: no more repeats.
                     hold_btn <= REP_NONE;
                  end
               end
               CONFIRM: begin
                  if (!chop) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
               DONE: ;
               default: begin
                  state   <= IDLE;
                  editing <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_name_entry.sv
// Directed bench for name_entry with short repeat timing (delay 4, period 2);
// expected values are hand-computed from the button sequence.
module tb_name_entry;

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic [4:0]       btn;
   logic             left, right, up, down, chop;
   logic [2:0][7:0]  name;
   logic [1:0]       cursor;
   logic             editing;
   logic             done;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [4:0] B_LEFT  = 5'b00001;
   localparam logic [4:0] B_RIGHT = 5'b00010;
   localparam logic [4:0] B_DOWN  = 5'b00100;
   localparam logic [4:0] B_UP    = 5'b01000;
   localparam logic [4:0] B_CHOP  = 5'b10000;

   assign {chop, up, down, right, left} = btn;

   always #5 clock = ~clock;

   name_entry #(
      .NUM_CHARS    (3),
      .CHAR_LO      (8'h41),
      .CHAR_HI      (8'h5A),
      .REPEAT_DELAY (4),
      .REPEAT_PERIOD(2)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .left   (left),
      .right  (right),
      .up     (up),
      .down   (down),
      .chop   (chop),
      .name   (name),
      .cursor (cursor),
      .editing(editing),
      .done   (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [4:0] b);
      btn = b;
      tick(1);
      btn = '0;
      tick(1);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      btn    = '0;
      tick(2);
      reset = 1'b0;
      chk("rst_name",    32'(name),    32'h414141);
      chk("rst_cursor",  32'(cursor),  32'd0);
      chk("rst_editing", 32'(editing), 32'd0);
      chk("rst_done",    32'(done),    32'd0);

      enable = 1'b1;
      tick(2);
      chk("arm_to_edit", 32'(editing), 32'd1);

      press(B_DOWN);
      chk("down_a_to_b", 32'(name),    32'h424141);
      chk("down_cursor", 32'(cursor),  32'd0);
      chk("down_edit",   32'(editing), 32'd1);

      press(B_UP);
      chk("up_b_to_a",   32'(name), 32'h414141);
      press(B_UP);
      chk("up_wrap_z",   32'(name), 32'h5A4141);
      press(B_DOWN);
      chk("down_wrap_a", 32'(name), 32'h414141);

      press(B_RIGHT);
      chk("right_1", 32'(cursor), 32'd1);
      press(B_RIGHT);
      chk("right_2", 32'(cursor), 32'd2);
      press(B_RIGHT);
      chk("right_sat", 32'(cursor), 32'd2);
      press(B_LEFT);
      press(B_LEFT);
      chk("left_1", 32'(cursor), 32'd0);
      press(B_LEFT);
      chk("left_sat", 32'(cursor), 32'd0);

      // Hold down 10 sampled edges: steps at t, t+4, t+6, t+8.
      btn = B_DOWN;
      tick(4);
      chk("hold_before_delay", 32'(name), 32'h424141);
      tick(1);
      chk("hold_first_repeat", 32'(name), 32'h434141);
      tick(5);
      chk("hold_ten_cycles", 32'(name), 32'h454141);
      btn = '0;
      tick(4);
      chk("release_no_step", 32'(name),    32'h454141);
      chk("release_editing", 32'(editing), 32'd1);

      press(B_UP | B_DOWN);
      chk("up_beats_down", 32'(name), 32'h444141);

      btn = B_DOWN;
      tick(1);
      chk("down_before_chop", 32'(name), 32'h454141);
      btn = B_DOWN | B_CHOP;
      tick(2);
      chk("chop_in_hold_edit", 32'(editing), 32'd1);
      chk("chop_in_hold_done", 32'(done),    32'd0);
      btn = '0;
      tick(1);
      chk("chop_in_hold_name", 32'(name), 32'h454141);

      enable = 1'b0;
      tick(1);
      chk("enable_drop_idle", 32'(editing), 32'd0);

      btn    = B_CHOP;
      enable = 1'b1;
      tick(4);
      chk("arm_chop_held", 32'(editing), 32'd0);
      btn = '0;
      tick(1);
      chk("arm_released", 32'(editing), 32'd1);
      btn = B_CHOP;
      tick(2);
      chk("confirm_wait_done", 32'(done),    32'd0);
      chk("confirm_editing",   32'(editing), 32'd0);
      btn = '0;
      tick(1);
      chk("done_pulse", 32'(done), 32'd1);
      tick(1);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("done_name",      32'(name), 32'h454141);
      tick(2);
      chk("done_no_repeat", 32'(done), 32'd0);

      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(2);
      chk("reentry_editing", 32'(editing), 32'd1);
      press(B_RIGHT);
      press(B_DOWN);
      chk("reentry_mid_char", 32'(name), 32'h454241);

      btn   = B_DOWN;
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      btn   = '0;
      chk("midreset_name",    32'(name),    32'h414141);
      chk("midreset_cursor",  32'(cursor),  32'd0);
      chk("midreset_editing", 32'(editing), 32'd0);
      chk("midreset_done",    32'(done),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/name_entry.md
# name_entry

Parametrised text-entry controller for the welcome menu: the player edits a fixed-length team name one character at a time with the direction buttons and confirms it with chop. It generalises the three-letter welcome-menu entry to any name length and character range. It adds hold-to-repeat on up/down, an explicit arm/confirm handshake, and a one-cycle `done` pulse for the game-state controller. It sits between the debounced button inputs and the top-level game FSM, which reads `name` for display and score upload.

## Interface
- `NUM_CHARS`, 3: name length in characters; must be at least 1.
- `CHAR_LO`, 8'h41: lowest legal character code ('A').
- `CHAR_HI`, 8'h5A: highest legal character code ('Z'); requires `CHAR_HI` > `CHAR_LO`.
- `REPEAT_DELAY`, 25_000_000: cycles up/down must stay held before the first auto-repeat step; must be at least 1.
- `REPEAT_PERIOD`, 5_000_000: cycles between later auto-repeat steps; must be at least 1.

- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: high while the game FSM is in the welcome menu.
- `left`, `right`, `up`, `down`, `chop`, in, 1 each: debounced, synchronised, level-high buttons.
- `name`, out, [NUM_CHARS-1:0][7:0]: name characters; `name[NUM_CHARS-1]` is the leftmost (first) character.
- `cursor`, out, $clog2(NUM_CHARS) (min 1): selected position, 0 = leftmost, so it edits `name[NUM_CHARS-1-cursor]`.
- `editing`, out, 1: high in EDIT and HOLD.
- `done`, out, 1: one-cycle pulse when the name is confirmed.

## Operation
- State is 3 bits. States: IDLE, ARM, EDIT, HOLD, CONFIRM, DONE.
- `any` = OR of all five buttons.
- IDLE: if `enable`, go to ARM and set cursor to 0. `name` is kept, so an earlier name survives re-entry.
- ARM: wait for `any`=0, then go to EDIT. This stops a button held from the previous screen from acting.
- EDIT, on a cycle with `any`=1, act on one button by priority chop > up > down > right > left:
  - chop: go to CONFIRM.
  - up: selected character minus 1; `CHAR_LO` wraps to `CHAR_HI`. Go to HOLD.
  - down: selected character plus 1; `CHAR_HI` wraps to `CHAR_LO`. Go to HOLD.
  - right: cursor plus 1, saturating at `NUM_CHARS-1`. Go to HOLD.
  - left: cursor minus 1, saturating at 0. Go to HOLD.
- HOLD: records which button started the press. Go back to EDIT once `any`=0. No other button acts while in HOLD.
- Auto-repeat, up/down only: if the originating button is still high `REPEAT_DELAY` cycles after the initial step, apply one more step. After that, apply a step every `REPEAT_PERIOD` cycles while it stays high. Left and right never repeat.
- Character arithmetic is 8-bit with explicit compare-and-wrap. A character outside [`CHAR_LO`,`CHAR_HI`] steps to `CHAR_LO` on down and to `CHAR_HI` on up.
- CONFIRM: wait for `chop`=0, then pulse `done` and go to DONE.
- DONE: hold `name` and the cursor. Go to IDLE when `enable`=0.
- `enable`=0 in any state except IDLE: go to IDLE next cycle. Name and cursor are kept. No `done` pulse, including from CONFIRM.

## Timing
- Reset values:
  - `name` = all `CHAR_LO`
  - `cursor` = 0
  - `editing` = 0
  - `done` = 0
  - state = IDLE
  - repeat counter = 0
- Reset asserted mid-operation has the same effect on the next edge.
- Latency: a button sampled high in EDIT at edge t changes `name` or `cursor` at edge t (visible after it). HOLD is entered on that same edge.
- Auto-repeat steps land at edges t+`REPEAT_DELAY`, then t+`REPEAT_DELAY`+k·`REPEAT_PERIOD` for k ≥ 1.
- Releasing the button stops repeating immediately. A release on the same edge as a scheduled step suppresses that step.
- `done` is high exactly one cycle: the cycle after the edge at which `chop`=0 is first sampled in CONFIRM.
- Simultaneous presses in EDIT: only the highest-priority button acts. Extra buttons pressed during HOLD are ignored until all are released.
- Counter width is $clog2(max(`REPEAT_DELAY`,`REPEAT_PERIOD`)+1). The counter clears on entry to HOLD and after each repeat step.

## Test plan
Bench parameters: `NUM_CHARS`=3, `REPEAT_DELAY`=4, `REPEAT_PERIOD`=2.
- Reset, then `enable`=1 with all buttons low, then one `down` pulse → `name` = "BAA" ('B' in `name[2]`), `cursor`=0, `editing`=1.
- `up` pulse on 'A' → 'Z'. `down` pulse on 'Z' → 'A'.
- `right` ×3 → `cursor`=2 (saturated). `left` ×3 → `cursor`=0.
- Hold `down` for 10 cycles from 'A' → steps at t, t+4, t+6, t+8, giving 'E'. Release → no further change.
- Press `up` and `down` on the same cycle → only `up` applies. Press `chop` while `down` is held → ignored until `down` is released.
- `enable` rises while `chop` is held → stays in ARM. Release, then press and release `chop` → `done` high for exactly 1 cycle, `name` unchanged. Drop `enable` → IDLE. Assert `reset` mid-edit → "AAA", `cursor`=0.
